// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: datapath widths and opcode encodings.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int SHAMT_W   = 5;
  localparam int OPC_W     = 5;

  localparam logic [OPC_W-1:0] OP_ADD = 5'b00000;
  localparam logic [OPC_W-1:0] OP_SUB = 5'b00001;
  localparam logic [OPC_W-1:0] OP_AND = 5'b00010;
  localparam logic [OPC_W-1:0] OP_OR  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SLL = 5'b00100;
  localparam logic [OPC_W-1:0] OP_SRA = 5'b00101;

endpackage

// File: rtl/alu_adder32.sv
// Two's-complement adder with carry-in; reports signed overflow of the addition.
module alu_adder32
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    cin,
  output logic signed [WIDTH-1:0] sum,
  output logic                    ovf
);

  logic signed [WIDTH-1:0] cin_ext;

  assign cin_ext = $signed({{(WIDTH-1){1'b0}}, cin});
  assign sum     = a + b + cin_ext;

  // Subtraction callers pass ~B, so the same-sign rule covers both ADD and SUB.
  assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_unit.sv
// Execute-stage ALU: combinational operation select followed by one output register stage.
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] data_operandA,
  input  logic signed [WIDTH-1:0] data_operandB,
  input  logic [OPC_W-1:0]        ctrl_ALUopcode,
  input  logic [SHAMT_W-1:0]      ctrl_shiftamt,
  output logic signed [WIDTH-1:0] data_result,
  output logic                    isNotEqual,
  output logic                    isLessThan,
  output logic                    overflow
);

  logic signed [WIDTH-1:0] b_inv_p0;
  logic signed [WIDTH-1:0] sum_p0;
  logic signed [WIDTH-1:0] diff_p0;
  logic signed [WIDTH-1:0] result_p0;
  logic                    add_ovf_p0;
  logic                    sub_ovf_p0;
  logic                    ovf_p0;
  logic                    ne_p0;
  logic                    lt_p0;

  logic signed [WIDTH-1:0] result_p1;
  logic                    ovf_p1;
  logic                    ne_p1;
  logic                    lt_p1;

  assign b_inv_p0 = ~data_operandB;

  alu_adder32 #(.WIDTH(WIDTH)) u_add (
    .a   (data_operandA),
    .b   (data_operandB),
    .cin (1'b0),
    .sum (sum_p0),
    .ovf (add_ovf_p0)
  );

  // Subtract path runs every cycle so the compare flags never depend on the opcode.
  alu_adder32 #(.WIDTH(WIDTH)) u_sub (
    .a   (data_operandA),
    .b   (b_inv_p0),
    .cin (1'b1),
    .sum (diff_p0),
    .ovf (sub_ovf_p0)
  );

  assign ne_p0 = |diff_p0;
  assign lt_p0 = diff_p0[WIDTH-1] ^ sub_ovf_p0;

  always_comb begin
    result_p0 = '0;
    ovf_p0    = 1'b0;
    case (ctrl_ALUopcode)
      OP_ADD: begin
        result_p0 = sum_p0;
        ovf_p0    = add_ovf_p0;
      end
      OP_SUB: begin
        result_p0 = diff_p0;
        ovf_p0    = sub_ovf_p0;
      end
      OP_AND: result_p0 = data_operandA & data_operandB;
      OP_OR:  result_p0 = data_operandA | data_operandB;
      OP_SLL: result_p0 = data_operandA << ctrl_shiftamt;
      OP_SRA: result_p0 = data_operandA >>> ctrl_shiftamt;
      default: ;
    endcase
  end

  // p0 -> p1: output register stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_p1 <= '0;
      ovf_p1    <= 1'b0;
      ne_p1     <= 1'b0;
      lt_p1     <= 1'b0;
    end else begin
      result_p1 <= result_p0;
      ovf_p1    <= ovf_p0;
      ne_p1     <= ne_p0;
      lt_p1     <= lt_p0;
    end
  end

  assign data_result = result_p1;
  assign overflow    = ovf_p1;
  assign isNotEqual  = ne_p1;
  assign isLessThan  = lt_p1;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed literal cases plus randomized stimulus against a behavioural model.
module tb_alu_unit;
  import alu_pkg::*;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic signed [31:0] a;
  logic signed [31:0] b;
  logic [4:0]         op;
  logic [4:0]         sh;
  logic signed [31:0] data_result;
  logic               isNotEqual;
  logic               isLessThan;
  logic               overflow;

  int checks = 0;
  int errors = 0;

  alu_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (a),
    .data_operandB  (b),
    .ctrl_ALUopcode (op),
    .ctrl_shiftamt  (sh),
    .data_result    (data_result),
    .isNotEqual     (isNotEqual),
    .isLessThan     (isLessThan),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference model from plain signed arithmetic on 64-bit integers.
  task automatic model(input logic [31:0] ai, input logic [31:0] bi, input logic [4:0] o,
                       input logic [4:0] s, output logic [31:0] r, output logic ne,
                       output logic lt, output logic ov);
    longint sa;
    longint sb;
    longint t;
    sa = longint'($signed(ai));
    sb = longint'($signed(bi));
    r  = 32'h0;
    ov = 1'b0;
    case (o)
      5'd0: begin
        t  = sa + sb;
        r  = t[31:0];
        ov = (longint'($signed(t[31:0])) != t);
      end
      5'd1: begin
        t  = sa - sb;
        r  = t[31:0];
        ov = (longint'($signed(t[31:0])) != t);
      end
      5'd2: r = ai & bi;
      5'd3: r = ai | bi;
      5'd4: r = ai << s;
      5'd5: r = $signed(ai) >>> s;
      default: ;
    endcase
    ne = (sa != sb);
    lt = (sa < sb);
  endtask

  // Every-cycle comparison of the registered outputs against the model.
  initial begin
    logic [31:0] er;
    logic        ene;
    logic        elt;
    logic        eov;
    forever begin
      @(posedge clock);
      if (reset) begin
        er = 32'h0; ene = 1'b0; elt = 1'b0; eov = 1'b0;
      end else begin
        model(a, b, op, sh, er, ene, elt, eov);
      end
      #1;
      if (reset) begin
        er = 32'h0; ene = 1'b0; elt = 1'b0; eov = 1'b0;
      end
      chk32("cyc_result", data_result, er);
      chk1("cyc_ne", isNotEqual, ene);
      chk1("cyc_lt", isLessThan, elt);
      chk1("cyc_ovf", overflow, eov);
    end
  end

  task automatic dir(input string name, input logic [4:0] o, input logic [31:0] ai,
                     input logic [31:0] bi, input logic [4:0] s, input logic [31:0] er,
                     input logic ene, input logic elt, input logic eov);
    @(negedge clock);
    op = o; a = ai; b = bi; sh = s;
    @(posedge clock);
    #2;
    chk32({name, "_result"}, data_result, er);
    chk1({name, "_ne"}, isNotEqual, ene);
    chk1({name, "_lt"}, isLessThan, elt);
    chk1({name, "_ovf"}, overflow, eov);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners [5];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h7FFF_FFFF;
    corners[4] = 32'h8000_0000;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    a = '0; b = '0; op = '0; sh = '0;
    #1 reset = 1'b1;
    #1;
    chk32("rst_result", data_result, 32'h0);
    chk1("rst_ne", isNotEqual, 1'b0);
    chk1("rst_lt", isLessThan, 1'b0);
    chk1("rst_ovf", overflow, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    dir("sub_34_16",  OP_SUB, 32'd34,        32'd16,        5'd5,  32'd18,        1'b0 | 1'b1, 1'b0, 1'b0);
    dir("add_ovf",    OP_ADD, 32'h7FFF_FFFF, 32'h1,         5'd0,  32'h8000_0000, 1'b1, 1'b0, 1'b1);
    dir("add_5_5",    OP_ADD, 32'd5,         32'd5,         5'd0,  32'd10,        1'b0, 1'b0, 1'b0);
    dir("sub_ovf",    OP_SUB, 32'h8000_0000, 32'h1,         5'd0,  32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
    dir("sub_m3_2",   OP_SUB, 32'hFFFF_FFFD, 32'd2,         5'd0,  32'hFFFF_FFFB, 1'b1, 1'b1, 1'b0);
    dir("and",        OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7,  32'hF000_F000, 1'b1, 1'b1, 1'b0);
    dir("or",         OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7,  32'hFFF0_FFF0, 1'b1, 1'b1, 1'b0);
    dir("sll_31",     OP_SLL, 32'h1,         32'h0,         5'd31, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    dir("sra_4",      OP_SRA, 32'h8000_0000, 32'h0,         5'd4,  32'hF800_0000, 1'b1, 1'b1, 1'b0);
    dir("sra_30",     OP_SRA, 32'h4000_0000, 32'h0,         5'd30, 32'h1,         1'b1, 1'b0, 1'b0);
    dir("sll_0",      OP_SLL, 32'h1234_5678, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges while an ADD result is held.
    dir("pre_rst",    OP_ADD, 32'd5,         32'd5,         5'd0,  32'd10,        1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk32("async_rst_result", data_result, 32'h0);
    chk1("async_rst_ne", isNotEqual, 1'b0);
    chk1("async_rst_lt", isLessThan, 1'b0);
    chk1("async_rst_ovf", overflow, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    dir("illegal_op", 5'b11111, 32'd3,       32'd7,         5'd3,  32'h0,         1'b1, 1'b1, 1'b0);

    repeat (3000) begin
      @(negedge clock);
      a  = pick();
      b  = ($urandom_range(0, 7) == 0) ? a : pick();
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(6, 31)) : 5'($urandom_range(0, 5));
      sh = 5'($urandom_range(0, 31));
    end
    @(negedge clock);
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 32-bit two's-complement ALU with registered outputs; the execute-stage arithmetic block of the processor datapath.
- Performs add, subtract, AND, OR, logical left shift and arithmetic right shift.
- Produces the comparison flags (isNotEqual, isLessThan) and a signed overflow flag.
- All outputs are registered: one clock of latency from operand capture to result.

Parameters:
- WIDTH, 32, datapath width of operands and result (shift amount width is fixed at 5; only WIDTH=32 is required to be supported).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset; clears all output registers
- data_operandA  input  32  operand A, signed two's complement
- data_operandB  input  32  operand B, signed two's complement
- ctrl_ALUopcode  input  5  operation select
- ctrl_shiftamt  input  5  shift distance for SLL/SRA (0..31)
- data_result  output  32  registered result
- isNotEqual  output  1  registered; 1 when A != B
- isLessThan  output  1  registered; 1 when A < B (signed)
- overflow  output  1  registered; signed overflow of ADD/SUB

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: while reset=1, data_result=0, isNotEqual=0, isLessThan=0, overflow=0, regardless of clock.
  - Assertion mid-operation clears outputs immediately; any in-flight result is discarded.
  - The first rising edge after deassertion captures fresh inputs.
- Latency: inputs are sampled on a rising edge of clock; outputs reflect that sample until the next edge. No handshake; a new operation is accepted every cycle.
- Opcodes (binary):
  - 00000 ADD: A+B mod 2^32
  - 00001 SUB: A-B mod 2^32
  - 00010 AND: bitwise
  - 00011 OR: bitwise
  - 00100 SLL: A << shiftamt, zero fill
  - 00101 SRA: A >>> shiftamt, sign fill from A[31]
  - All other opcodes: result=0, overflow=0.
- overflow:
  - ADD: set when A and B have equal sign and the result sign differs.
  - SUB: set when A and B have different sign and the result sign differs from A.
  - 0 for every other opcode.
- isNotEqual and isLessThan are computed from the internal difference A-B on every cycle, independent of opcode:
  - isNotEqual = (A-B) != 0.
  - isLessThan = sign(A-B) XOR subtraction-overflow, which gives a correct signed compare at the extremes.
- Shift amount 0 passes A through unchanged; B is ignored for SLL/SRA.
- ctrl_shiftamt is ignored for non-shift opcodes.
- No X propagation on valid inputs; all outputs are fully defined after reset.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRA
  - WIDTH and shift-amount width constants.
- One natural sub-module, alu_adder32: 32-bit adder (carry-lookahead acceptable) with carry-in, used for ADD and for SUB (B inverted, cin=1).
  - Returns sum and signed-overflow.
  - The same instance's SUB path drives the comparison flags.
- Shifters and logic ops stay inline in alu_unit.

Test Plan:
- SUB A=34, B=16, shiftamt=5 -> after one edge: result=18, isNotEqual=1, isLessThan=0, overflow=0.
- ADD A=0x7FFFFFFF, B=1 -> result=0x80000000, overflow=1. Then ADD A=B=5 -> result=10, isNotEqual=0, overflow=0.
- SUB A=0x80000000, B=1 -> result=0x7FFFFFFF, overflow=1, isLessThan=1. Then SUB A=-3, B=2 -> result=-5, isLessThan=1, overflow=0.
- AND/OR with A=0xF0F0F0F0, B=0xFF00FF00 -> 0xF000F000 and 0xFFF0FFF0; overflow=0 for both.
- SLL A=1, shiftamt=31 -> 0x80000000. SRA A=0x80000000, shiftamt=4 -> 0xF8000000. SRA A=0x40000000, shiftamt=30 -> 1.
- Reset and illegal opcode:
  - Raise reset between edges during a valid ADD -> all outputs 0 immediately, without a clock edge.
  - Release reset, then apply opcode 11111 -> result=0, overflow=0.
